// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdb_arbiter_if : result-request and CDB broadcast bundle.  Rev 1.0
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 2,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [TAG_W-1:0]          rob_head;
  logic                      cdb_stall;
  logic                      flush;
  logic [NUM_REQ-1:0]        gnt;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [1:0]                cdb_src;
  logic [CNT_W-1:0]          conflict_cnt;

  modport master (
    output req, req_tag, req_data, rob_head, cdb_stall, flush,
    input  gnt, cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt
  );

  modport slave (
    input  req, req_tag, req_data, rob_head, cdb_stall, flush,
    output gnt, cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdb_arbiter : oldest-first (ROB-head relative) arbiter for the CDB.  Rev 1.0
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 2,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cdb_arbiter_if.slave   bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int POP_W = $clog2(NUM_REQ + 1);

  logic [TAG_W-1:0]  age [NUM_REQ];
  logic              any_req;
  logic [IDX_W-1:0]  win_idx;
  logic [TAG_W-1:0]  best_age;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic [POP_W-1:0]  req_cnt;
  logic              multi_req;
  logic              grant_ok;
  logic [NUM_REQ-1:0] gnt_vec;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [1:0]        cdb_src_q;
  logic [CNT_W-1:0]  conflict_q;

  // Age wraps naturally in TAG_W bits, so the head itself is age 0.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
      assign age[i] = bus.req_tag[i*TAG_W +: TAG_W] - bus.rob_head;
    end
  endgenerate

  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    best_age = '0;
    win_tag  = '0;
    win_data = '0;
    req_cnt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cnt = req_cnt + POP_W'(bus.req[i]);
      // Strict compare keeps the lowest index on an (illegal) age tie.
      if (bus.req[i] && (!any_req || (age[i] < best_age))) begin
        any_req  = 1'b1;
        best_age = age[i];
        win_idx  = IDX_W'(i);
        win_tag  = bus.req_tag[i*TAG_W +: TAG_W];
        win_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign multi_req = (req_cnt > POP_W'(1));
  assign grant_ok  = any_req && !bus.cdb_stall && !bus.flush && rst_n;

  always_comb begin
    gnt_vec = '0;
    if (grant_ok) begin
      gnt_vec[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      conflict_q  <= '0;
    end else begin
      if (bus.flush) begin
        cdb_valid_q <= 1'b0;
      end else if (grant_ok) begin
        cdb_valid_q <= 1'b1;
        cdb_tag_q   <= win_tag;
        cdb_data_q  <= win_data;
        cdb_src_q   <= 2'(win_idx);
      end else begin
        cdb_valid_q <= 1'b0;
      end

      if (multi_req && !bus.flush && (conflict_q != {CNT_W{1'b1}})) begin
        conflict_q <= conflict_q + CNT_W'(1);
      end
    end
  end

  assign bus.gnt          = gnt_vec;
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_tag      = cdb_tag_q;
  assign bus.cdb_data     = cdb_data_q;
  assign bus.cdb_src      = cdb_src_q;
  assign bus.conflict_cnt = conflict_q;
endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cdb_arbiter : scoreboard bench for cdb_arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(3), .TAG_W(2), .DATA_W(32), .CNT_W(16)) bus ();
  cdb_arbiter_if #(.NUM_REQ(3), .TAG_W(2), .DATA_W(32), .CNT_W(4))  bus_s ();

  cdb_arbiter #(.NUM_REQ(3), .TAG_W(2), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  cdb_arbiter #(.NUM_REQ(3), .TAG_W(2), .DATA_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] data;
    logic [1:0]  src;
  } bcast_t;

  bcast_t      sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] dat [3];

  // Every cycle out of reset: a queued entry must be on the bus, else idle.
  always @(negedge clk) begin : monitor
    bcast_t e;
    if (rst_n) begin
      total++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== e.tag ||
            bus.cdb_data !== e.data || bus.cdb_src !== e.src) begin
          bad++;
          $display("FAIL cdb_bcast t=%0t: got v=%b tag=%0d data=%h src=%0d want v=1 tag=%0d data=%h src=%0d",
                   $time, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src, e.tag, e.data, e.src);
        end
      end else if (bus.cdb_valid !== 1'b0) begin
        bad++;
        $display("FAIL cdb_idle t=%0t: got v=%b want v=0", $time, bus.cdb_valid);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    dat[0] = d0; dat[1] = d1; dat[2] = d2;
    bus.req_data = {d2, d1, d0};
  endtask

  task automatic set_req(input logic [2:0] r, input logic [1:0] t0, input logic [1:0] t1,
                         input logic [1:0] t2, input logic [1:0] head);
    bus.req      = r;
    bus.req_tag  = {t2, t1, t0};
    bus.rob_head = head;
  endtask

  task automatic end_cycle(input logic push, input logic [1:0] tag, input logic [31:0] data,
                           input logic [1:0] src);
    @(posedge clk);
    if (push) sb.push_back({tag, data, src});
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.cdb_stall = 1'b0; bus.flush = 1'b0;
    bus_s.req = '0; bus_s.cdb_stall = 1'b0; bus_s.flush = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [2:0] model_pick(input logic [2:0] pend, input logic [5:0] tags,
                                            input logic [1:0] head);
    logic [2:0] res = 3'b000;
    logic [1:0] t;
    for (int a = 0; a < 4; a++) begin
      for (int i = 0; i < 3; i++) begin
        t = tags[i*2 +: 2];
        if (!res[2] && pend[i] && (2'(t - head) == 2'(a))) res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    sb.delete();
    set_data(32'h1111_0000, 32'h2222_0001, 32'h3333_0002);
    set_req(3'b111, 2'd0, 2'd1, 2'd2, 2'd0);
    @(negedge clk);
    total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
    total++; if (bus.cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.cdb_valid); end
    total++; if (bus.conflict_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.conflict_cnt); end
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL reset_first_gnt: got %b want 001", bus.gnt); end
    end_cycle(1'b1, 2'd0, dat[0], 2'd0);
    bus.req = 3'b000;
    @(negedge clk);
    total++; if (bus.conflict_cnt !== 16'd1) begin bad++; $display("FAIL reset_cnt_after: got %0d want 1", bus.conflict_cnt); end
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
  endtask

  task automatic test_single();
    do_reset();
    set_data(32'h0, 32'h0000_00AA, 32'h0);
    set_req(3'b010, 2'd0, 2'd1, 2'd0, 2'd0);
    @(negedge clk);
    total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL single_gnt: got %b want 010", bus.gnt); end
    end_cycle(1'b1, 2'd1, 32'h0000_00AA, 2'd1);
    bus.req = 3'b000;
    repeat (2) end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
  endtask

  task automatic test_age_wrap();
    do_reset();
    set_data(32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002);
    set_req(3'b111, 2'd0, 2'd3, 2'd1, 2'd3);
    @(negedge clk);
    total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL wrap_gnt1: got %b want 010", bus.gnt); end
    end_cycle(1'b1, 2'd3, dat[1], 2'd1);
    bus.req = 3'b101;
    @(negedge clk);
    total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL wrap_gnt2: got %b want 001", bus.gnt); end
    end_cycle(1'b1, 2'd0, dat[0], 2'd0);
    bus.req = 3'b100;
    @(negedge clk);
    total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL wrap_gnt3: got %b want 100", bus.gnt); end
    end_cycle(1'b1, 2'd1, dat[2], 2'd2);
    bus.req = 3'b000;
    @(negedge clk);
    total++; if (bus.conflict_cnt !== 16'd2) begin bad++; $display("FAIL wrap_cnt: got %0d want 2", bus.conflict_cnt); end
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
  endtask

  task automatic test_stall();
    do_reset();
    set_data(32'hC000_0000, 32'hC000_0001, 32'hC000_0002);
    set_req(3'b001, 2'd3, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL stall_pre_gnt: got %b want 001", bus.gnt); end
    end_cycle(1'b1, 2'd3, dat[0], 2'd0);
    // The broadcast registered above must still appear during the stall.
    set_req(3'b110, 2'd0, 2'd1, 2'd2, 2'd0);
    bus.cdb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL stall_gnt%0d: got %b want 000", k, bus.gnt); end
      end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
    end
    bus.cdb_stall = 1'b0;
    @(negedge clk);
    total++; if (bus.conflict_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt: got %0d want 3", bus.conflict_cnt); end
    total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL stall_rel_gnt1: got %b want 010", bus.gnt); end
    end_cycle(1'b1, 2'd1, dat[1], 2'd1);
    bus.req = 3'b100;
    @(negedge clk);
    total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL stall_rel_gnt2: got %b want 100", bus.gnt); end
    end_cycle(1'b1, 2'd2, dat[2], 2'd2);
    bus.req = 3'b000;
    @(negedge clk);
    total++; if (bus.conflict_cnt !== 16'd4) begin bad++; $display("FAIL stall_cnt_end: got %0d want 4", bus.conflict_cnt); end
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
  endtask

  task automatic test_flush();
    do_reset();
    set_data(32'hF000_0000, 32'hF000_0001, 32'hF000_0002);
    set_req(3'b001, 2'd2, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL flush_pre_gnt: got %b want 001", bus.gnt); end
    end_cycle(1'b1, 2'd2, dat[0], 2'd0);
    set_req(3'b011, 2'd1, 2'd0, 2'd0, 2'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    total++; if (bus.gnt !== 3'b000) begin bad++; $display("FAIL flush_gnt: got %b want 000", bus.gnt); end
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
    bus.flush = 1'b0;
    bus.req = 3'b000;
    @(negedge clk);
    total++; if (bus.cdb_tag !== 2'd2 || bus.cdb_src !== 2'd0) begin
      bad++; $display("FAIL flush_hold: got tag=%0d src=%0d want tag=2 src=0", bus.cdb_tag, bus.cdb_src);
    end
    total++; if (bus.conflict_cnt !== 16'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", bus.conflict_cnt); end
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_data(32'h0, 32'h0, 32'hB000_0000 + 32'(k));
      set_req(3'b100, 2'd0, 2'd0, 2'(k), 2'd0);
      @(negedge clk);
      total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL b2b_gnt%0d: got %b want 100", k, bus.gnt); end
      end_cycle(1'b1, 2'(k), dat[2], 2'd2);
    end
    bus.req = 3'b000;
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_data(32'hDEAD_BEEF, 32'h0, 32'h0);
    set_req(3'b001, 2'd3, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL areset_gnt: got %b want 001", bus.gnt); end
    @(posedge clk);
    #1;
    total++; if (bus.cdb_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid: got %b want 1", bus.cdb_valid); end
    #1 rst_n = 1'b0;
    bus.req = 3'b000;
    #1;
    total++; if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 2'd0 || bus.cdb_data !== 32'd0) begin
      bad++; $display("FAIL areset_clear: got v=%b tag=%0d data=%h want v=0 tag=0 data=0",
                      bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
  endtask

  task automatic test_random();
    logic [2:0] pend, exp_gnt, pk;
    logic [1:0] base, head;
    logic       stall;
    int         exp_cnt, guard;
    do_reset();
    exp_cnt = 0;
    for (int r = 0; r < 12; r++) begin
      base = 2'($urandom_range(0, 3));
      head = 2'($urandom_range(0, 3));
      pend = 3'($urandom_range(1, 7));
      set_data($urandom, $urandom, $urandom);
      set_req(pend, base, base + 2'd1, base + 2'd2, head);
      guard = 0;
      while (pend != 3'b000 && guard < 40) begin
        stall = ($urandom_range(0, 3) == 0);
        bus.req = pend;
        bus.cdb_stall = stall;
        pk = model_pick(pend, bus.req_tag, head);
        exp_gnt = (stall || !pk[2]) ? 3'b000 : (3'b001 << pk[1:0]);
        if ($countones(pend) >= 2) exp_cnt++;
        @(negedge clk);
        total++; if (bus.gnt !== exp_gnt) begin
          bad++; $display("FAIL rand_gnt r=%0d: got %b want %b", r, bus.gnt, exp_gnt);
        end
        end_cycle(exp_gnt != 3'b000, bus.req_tag[pk[1:0]*2 +: 2], dat[pk[1:0]], pk[1:0]);
        pend = pend & ~exp_gnt;
        guard++;
      end
      if (guard >= 40) begin
        total++; bad++; $display("FAIL rand_drain r=%0d: got pending=%b want 000", r, pend);
      end
    end
    bus.req = 3'b000;
    bus.cdb_stall = 1'b0;
    @(negedge clk);
    total++; if (bus.conflict_cnt !== 16'(exp_cnt)) begin
      bad++; $display("FAIL rand_cnt: got %0d want %0d", bus.conflict_cnt, exp_cnt);
    end
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
  endtask

  task automatic test_saturation();
    do_reset();
    bus_s.req = 3'b011;
    bus_s.req_tag = {2'd2, 2'd1, 2'd0};
    bus_s.req_data = '0;
    bus_s.rob_head = 2'd0;
    bus_s.cdb_stall = 1'b1;
    repeat (14) end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
    @(negedge clk);
    total++; if (bus_s.conflict_cnt !== 4'hE) begin bad++; $display("FAIL sat_cnt14: got %h want e", bus_s.conflict_cnt); end
    repeat (6) end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
    @(negedge clk);
    total++; if (bus_s.conflict_cnt !== 4'hF) begin bad++; $display("FAIL sat_cnt20: got %h want f", bus_s.conflict_cnt); end
    total++; if (bus_s.gnt !== 3'b000 || bus_s.cdb_valid !== 1'b0) begin
      bad++; $display("FAIL sat_quiet: got gnt=%b v=%b want gnt=000 v=0", bus_s.gnt, bus_s.cdb_valid);
    end
    bus_s.req = 3'b000;
    bus_s.cdb_stall = 1'b0;
    end_cycle(1'b0, 2'd0, 32'd0, 2'd0);
  endtask

  initial begin
    bus.req = '0; bus.req_tag = '0; bus.req_data = '0; bus.rob_head = '0;
    bus.cdb_stall = 1'b0; bus.flush = 1'b0;
    bus_s.req = '0; bus_s.req_tag = '0; bus_s.req_data = '0; bus_s.rob_head = '0;
    bus_s.cdb_stall = 1'b0; bus_s.flush = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_age_wrap();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_saturation();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
